// File: rtl/uart_alu_frame_engine_if.sv
// Byte-stream link between the frame engine and the UART RX/TX cores.
// slave = engine side, master = host/UART side.
interface uart_alu_frame_engine_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  tx_ready,
        output rx_ready,
        output tx_byte,
        output tx_valid
    );

    modport master (
        output rx_byte,
        output rx_valid,
        output tx_ready,
        input  rx_ready,
        input  tx_byte,
        input  tx_valid
    );
endinterface

// File: rtl/uart_alu_frame_engine.sv
// Framed UART add/sub engine: opcode + A + B in, status + result out.
// Chunked carry-propagate adder, inter-byte timeout, TX backpressure.
module uart_alu_frame_engine #(
    parameter int WIDTH       = 32,
    parameter int CHUNK       = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    uart_alu_frame_engine_if.slave link,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_err,
    output logic                   cout,
    output logic [15:0]            frame_cnt
);

    localparam int NB = WIDTH / 8;
    localparam int NC = WIDTH / CHUNK;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        CALC,
        TX_STAT,
        TX_RES
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [4:0]       byte_cnt;
    logic [7:0]       chunk_cnt;
    logic             carry;
    logic [TW-1:0]    tmo_cnt;
    logic             err_f;
    logic             zero_f;
    logic             ovf_f;

    logic             rx_acc;
    logic             tx_acc;
    logic             last_byte;
    logic             last_chunk;
    logic             tmo_hit;
    logic             in_rx;
    logic             is_add;
    logic             is_sub;
    logic             op_err;
    int               base;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] r_new;
    logic             ovf_new;

    // Handshake qualifiers and one chunk of the carry-propagate adder.
    always_comb begin
        in_rx      = (state == RX_A) || (state == RX_B);
        rx_acc     = link.rx_valid && link.rx_ready;
        tx_acc     = link.tx_valid && link.tx_ready;
        last_byte  = byte_cnt == 5'(NB - 1);
        last_chunk = chunk_cnt == 8'(NC - 1);
        tmo_hit    = tmo_cnt == TW'(TIMEOUT_CYC - 1);
        is_add     = op == 8'h00;
        is_sub     = op == 8'h01;
        op_err     = !(is_add || is_sub);
        base       = CHUNK * int'(chunk_cnt);
        a_ch       = CHUNK'(a >> base);
        b_ch       = CHUNK'(b >> base);
        if (is_sub) begin
            b_ch = ~b_ch;
        end
        sum   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        r_new = r;
        if (!op_err) begin
            r_new = r | (WIDTH'(sum[CHUNK-1:0]) << base);
        end
        ovf_new = 1'b0;
        if (is_add) begin
            ovf_new = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (r_new[WIDTH-1] != a[WIDTH-1]);
        end else if (is_sub) begin
            ovf_new = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (r_new[WIDTH-1] != a[WIDTH-1]);
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and link outputs.
    always_comb begin
        state_nx      = state;
        link.rx_ready = 1'b0;
        link.tx_valid = 1'b0;
        link.tx_byte  = 8'h00;
        busy          = state != IDLE;
        unique case (state)
            IDLE: begin
                link.rx_ready = !rst;
                if (rx_acc) begin
                    state_nx = RX_A;
                end
            end
            RX_A: begin
                link.rx_ready = !rst;
                if (rx_acc && last_byte) begin
                    state_nx = RX_B;
                end else if (!rx_acc && tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            RX_B: begin
                link.rx_ready = !rst;
                if (rx_acc && last_byte) begin
                    state_nx = CALC;
                end else if (!rx_acc && tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (last_chunk) begin
                    state_nx = TX_STAT;
                end
            end
            TX_STAT: begin
                link.tx_valid = 1'b1;
                link.tx_byte  = {err_f, 4'b0000, zero_f, ovf_f, cout};
                if (link.tx_ready) begin
                    state_nx = TX_RES;
                end
            end
            TX_RES: begin
                link.tx_valid = 1'b1;
                link.tx_byte  = r[WIDTH-1 -: 8];
                if (link.tx_ready && last_byte) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, chunked add, flags, result shift-out.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            op        <= '0;
            a         <= '0;
            b         <= '0;
            r         <= '0;
            byte_cnt  <= '0;
            chunk_cnt <= '0;
            carry     <= 1'b0;
            tmo_cnt   <= '0;
            err_f     <= 1'b0;
            zero_f    <= 1'b0;
            ovf_f     <= 1'b0;
            cout      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_acc) begin
                        op       <= link.rx_byte;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                RX_A, RX_B: begin
                    if (rx_acc) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= last_byte ? 5'd0 : byte_cnt + 5'd1;
                        if (state == RX_A) begin
                            a <= (a << 8) | WIDTH'(link.rx_byte);
                        end else begin
                            b <= (b << 8) | WIDTH'(link.rx_byte);
                        end
                        if (state == RX_B && last_byte) begin
                            chunk_cnt <= '0;
                            carry     <= is_sub;
                            r         <= '0;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        tmo_cnt   <= '0;
                        byte_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CALC: begin
                    r         <= r_new;
                    carry     <= sum[CHUNK];
                    chunk_cnt <= chunk_cnt + 8'd1;
                    if (last_chunk) begin
                        err_f  <= op_err;
                        cout   <= op_err ? 1'b0 : sum[CHUNK];
                        zero_f <= op_err ? 1'b1 : (r_new == '0);
                        ovf_f  <= ovf_new;
                    end
                end
                TX_STAT: begin
                end
                TX_RES: begin
                    if (tx_acc) begin
                        r <= r << 8;
                        if (last_byte) begin
                            byte_cnt  <= '0;
                            done      <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_engine.sv
// Bench for uart_alu_frame_engine: 32/8 directed frames and 64/16 sweep.
// Expected response bytes are queued at send time and popped on TX.
module tb_uart_alu_frame_engine;

    logic sys_clk = 1'b0;
    logic rst;

    always #5 sys_clk = ~sys_clk;

    uart_alu_frame_engine_if a_if ();
    uart_alu_frame_engine_if b_if ();

    logic        busy_a, done_a, ferr_a, cout_a;
    logic [15:0] cnt_a;
    logic        busy_b, done_b, ferr_b, cout_b;
    logic [15:0] cnt_b;

    uart_alu_frame_engine #(
        .WIDTH(32), .CHUNK(8), .TIMEOUT_CYC(50)
    ) u_a (
        .sys_clk(sys_clk), .rst(rst), .link(a_if),
        .busy(busy_a), .done(done_a), .frame_err(ferr_a),
        .cout(cout_a), .frame_cnt(cnt_a)
    );

    uart_alu_frame_engine #(
        .WIDTH(64), .CHUNK(16), .TIMEOUT_CYC(50)
    ) u_b (
        .sys_clk(sys_clk), .rst(rst), .link(b_if),
        .busy(busy_b), .done(done_b), .frame_err(ferr_b),
        .cout(cout_b), .frame_cnt(cnt_b)
    );

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic put(input bit sel, input logic [7:0] d);
        int n;
        n = 0;
        if (sel) begin
            b_if.rx_byte = d; b_if.rx_valid = 1'b1;
        end else begin
            a_if.rx_byte = d; a_if.rx_valid = 1'b1;
        end
        while (!(sel ? b_if.rx_ready : a_if.rx_ready) && n < 50) begin
            step(); n++;
        end
        if (n == 50) begin
            vectors++; errors++;
            $display("FAIL put rx_ready timeout byte=%02h", d);
        end
        step();
        a_if.rx_valid = 1'b0;
        b_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] op,
                              input logic [63:0] a, input logic [63:0] b);
        int nb;
        nb = sel ? 8 : 4;
        put(sel, op);
        for (int i = 0; i < nb; i++) put(sel, a[8*(nb-1-i) +: 8]);
        for (int i = 0; i < nb; i++) put(sel, b[8*(nb-1-i) +: 8]);
    endtask

    task automatic recv(input bit sel, input string tag);
        logic [7:0] e, g;
        int n;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        while (!(sel ? b_if.tx_valid : a_if.tx_valid) && n < 100) begin
            step(); n++;
        end
        if (n == 100) begin
            errors++;
            $display("FAIL %s tx_valid timeout, want byte %02h", tag, e);
        end else begin
            g = sel ? b_if.tx_byte : a_if.tx_byte;
            if (g !== e) begin
                errors++;
                $display("FAIL %s byte got %02h want %02h", tag, g, e);
            end
            step();
        end
    endtask

    task automatic recv_frame(input bit sel, input int nb, input string tag);
        for (int i = 0; i <= nb; i++) recv(sel, tag);
        vectors++;
        if ((sel ? done_b : done_a) !== 1'b1) begin
            errors++;
            $display("FAIL %s done got %b want 1", tag,
                     sel ? done_b : done_a);
        end
    endtask

    task automatic push5(input logic [7:0] s, input logic [31:0] r);
        exp_q.push_back(s);
        for (int i = 3; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        rst = 1'b1;
        step(); step();
        vectors++;
        if (a_if.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset rx_ready_in_rst got %b want 0", a_if.rx_ready);
        end
        rst = 1'b0;
        #1;
        outs = {busy_a, done_a, ferr_a, cout_a, a_if.tx_valid,
                a_if.tx_byte, cnt_a, 1'b0};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", outs);
        end
        vectors++;
        if (a_if.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset rx_ready got %b want 1", a_if.rx_ready);
        end
    endtask

    task automatic test_add_basic();
        int n;
        push5(8'h05, 32'h0000_0000);
        send_frame(0, 8'h00, 64'h1, 64'hFFFF_FFFF);
        n = 0;
        while (!a_if.tx_valid && n < 20) begin
            step(); n++;
        end
        vectors++;
        if (n != 4) begin
            errors++;
            $display("FAIL latency got %0d edges want 4", n);
        end
        recv_frame(0, 4, "add_basic");
        vectors++;
        if (cout_a !== 1'b1 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL add_basic cout/cnt got %b/%0d want 1/1",
                     cout_a, cnt_a);
        end
        step();
        vectors++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b want 0", done_a);
        end
    endtask

    task automatic test_sub();
        push5(8'h00, 32'hFFFF_FFFE);
        send_frame(0, 8'h01, 64'h5, 64'h7);
        recv_frame(0, 4, "sub");
        vectors++;
        if (cout_a !== 1'b0 || cnt_a !== 16'd2) begin
            errors++;
            $display("FAIL sub cout/cnt got %b/%0d want 0/2", cout_a, cnt_a);
        end
    endtask

    task automatic test_overflow();
        push5(8'h02, 32'h8000_0000);
        send_frame(0, 8'h00, 64'h7FFF_FFFF, 64'h1);
        recv_frame(0, 4, "add_ovf");
        push5(8'h03, 32'h7FFF_FFFF);
        send_frame(0, 8'h01, 64'h8000_0000, 64'h1);
        recv_frame(0, 4, "sub_ovf");
        vectors++;
        if (cout_a !== 1'b1 || cnt_a !== 16'd4) begin
            errors++;
            $display("FAIL ovf cout/cnt got %b/%0d want 1/4", cout_a, cnt_a);
        end
    endtask

    task automatic test_bad_opcode();
        push5(8'h84, 32'h0);
        send_frame(0, 8'h5A, 64'h1234_5678, 64'h9ABC_DEF0);
        recv_frame(0, 4, "bad_op");
        vectors++;
        if (cout_a !== 1'b0 || cnt_a !== 16'd5) begin
            errors++;
            $display("FAIL bad_op cout/cnt got %b/%0d want 0/5", cout_a, cnt_a);
        end
    endtask

    task automatic test_timeout();
        put(0, 8'h00); put(0, 8'h11); put(0, 8'h22);
        repeat (49) step();
        vectors++;
        if (ferr_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early ferr/busy got %b/%b want 0/1",
                     ferr_a, busy_a);
        end
        step();
        vectors++;
        if (ferr_a !== 1'b1 || busy_a !== 1'b0 || a_if.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fire ferr/busy/txv got %b/%b/%b want 1/0/0",
                     ferr_a, busy_a, a_if.tx_valid);
        end
        step();
        vectors++;
        if (ferr_a !== 1'b0 || cnt_a !== 16'd5) begin
            errors++;
            $display("FAIL tmo_after ferr/cnt got %b/%0d want 0/5",
                     ferr_a, cnt_a);
        end
        push5(8'h00, 32'h0000_0007);
        send_frame(0, 8'h00, 64'h3, 64'h4);
        recv_frame(0, 4, "tmo_recover");
    endtask

    task automatic test_expiry_byte();
        put(0, 8'h00); put(0, 8'h11);
        repeat (49) step();
        put(0, 8'h22);
        vectors++;
        if (ferr_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL expiry_byte ferr/busy got %b/%b want 0/1",
                     ferr_a, busy_a);
        end
        put(0, 8'h33); put(0, 8'h44);
        put(0, 8'h00); put(0, 8'h00); put(0, 8'h00); put(0, 8'h01);
        push5(8'h00, 32'h1122_3345);
        recv_frame(0, 4, "expiry_frame");
        vectors++;
        if (cnt_a !== 16'd7) begin
            errors++;
            $display("FAIL expiry cnt got %0d want 7", cnt_a);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        int n, bad;
        push5(8'h01, 32'h0000_0001);
        send_frame(0, 8'h00, 64'hFFFF_FFFF, 64'h2);
        recv(0, "bp_stat"); recv(0, "bp_r0"); recv(0, "bp_r1");
        e = exp_q.pop_front();
        n = 0;
        while (!a_if.tx_valid && n < 100) begin
            step(); n++;
        end
        a_if.tx_ready = 1'b0;
        bad = 0;
        repeat (20) begin
            step();
            if (a_if.tx_valid !== 1'b1 || a_if.tx_byte !== e) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold %0d unstable cycles, byte %02h want %02h",
                     bad, a_if.tx_byte, e);
        end
        a_if.tx_ready = 1'b1;
        step();
        recv(0, "bp_r3");
        vectors++;
        if (done_a !== 1'b1 || cout_a !== 1'b1 || cnt_a !== 16'd8) begin
            errors++;
            $display("FAIL bp_end done/cout/cnt got %b/%b/%0d want 1/1/8",
                     done_a, cout_a, cnt_a);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [29:0] outs;
        int seen;
        send_frame(0, 8'h00, 64'h1, 64'h1);
        step();
        rst = 1'b1;
        step();
        outs = {busy_a, done_a, ferr_a, cout_a, a_if.tx_valid,
                a_if.tx_byte, cnt_a, 1'b0};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_calc outputs got %h want 0", outs);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (a_if.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_calc rx_ready got %b want 1", a_if.rx_ready);
        end
        seen = 0;
        repeat (10) begin
            step();
            if (a_if.tx_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_calc stale tx_valid %0d cycles want 0", seen);
        end
        push5(8'h00, 32'h0000_0005);
        send_frame(0, 8'h00, 64'h2, 64'h3);
        recv_frame(0, 4, "rst_recover");
        vectors++;
        if (cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL rst_recover cnt got %0d want 1", cnt_a);
        end
    endtask

    task automatic test_sweep64();
        logic [7:0]  op, st;
        logic [63:0] a, b, r;
        logic [64:0] s;
        logic        v;
        for (int i = 0; i < 24; i++) begin
            op = (i % 8 == 7) ? 8'h33 : 8'(i % 2);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i == 0) begin a = '1; b = 64'h1; end
            if (i == 1) begin a = '0; b = '0; end
            if (i == 3) begin a = 64'h8000_0000_0000_0000; b = 64'h1; end
            if (op == 8'h00) s = {1'b0, a} + {1'b0, b};
            else if (op == 8'h01) s = {1'b0, a} + {1'b0, ~b} + 65'd1;
            else s = '0;
            r = s[63:0];
            v = 1'b0;
            if (op == 8'h00) v = (a[63] == b[63]) && (r[63] != a[63]);
            if (op == 8'h01) v = (a[63] != b[63]) && (r[63] != a[63]);
            st = {op > 8'h01, 4'b0000, r == 64'h0, v, s[64]};
            exp_q.push_back(st);
            for (int k = 7; k >= 0; k--) exp_q.push_back(r[8*k +: 8]);
            send_frame(1, op, a, b);
            recv_frame(1, 8, "sweep64");
            vectors++;
            if (cout_b !== s[64] || cnt_b !== 16'(i + 1)) begin
                errors++;
                $display("FAIL sweep64 #%0d cout/cnt got %b/%0d want %b/%0d",
                         i, cout_b, cnt_b, s[64], i + 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_if.rx_byte = 8'h00; a_if.rx_valid = 1'b0; a_if.tx_ready = 1'b1;
        b_if.rx_byte = 8'h00; b_if.rx_valid = 1'b0; b_if.tx_ready = 1'b1;
        test_reset();
        test_add_basic();
        test_sub();
        test_overflow();
        test_bad_opcode();
        test_timeout();
        test_expiry_byte();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
